// File: rtl/lsu_pkg.sv
// Shared types and constants for the LSU AXI-lite initiator: FSM states,
// access-size encodings and the AXI response code that counts as success.
package lsu_pkg;

  localparam int AXI_ADDR_BUS = 32;
  localparam int AXI_DATA_BUS = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_AR,
    S_R,
    S_WR,
    S_B
  } state_e;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10,
    SZ_X = 2'b11
  } size_e;

  localparam logic [1:0] RESP_OKAY = 2'b00;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store replication and strobes, load lane select
// with sign/zero extension, and detection of misaligned or illegal accesses.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]              offset,
  input  size_e                   size,
  input  logic                    is_unsigned,
  input  logic [AXI_DATA_BUS-1:0] store_data,
  input  logic [AXI_DATA_BUS-1:0] load_data,
  output logic [AXI_DATA_BUS-1:0] lane_wdata,
  output logic [3:0]              lane_wstrb,
  output logic [AXI_DATA_BUS-1:0] load_ext,
  output logic                    bad
);

  logic [AXI_DATA_BUS-1:0] shifted;

  // NOTE: every output gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    lane_wdata = '0;
    lane_wstrb = '0;
    load_ext   = '0;
    bad        = 1'b0;
    shifted    = load_data >> {offset, 3'b000};
    unique case (size)
      SZ_B: begin
        lane_wdata = {4{store_data[7:0]}};
        lane_wstrb = 4'b0001 << offset;
        load_ext   = {{24{~is_unsigned & shifted[7]}}, shifted[7:0]};
      end
      SZ_H: begin
        lane_wdata = {2{store_data[15:0]}};
        lane_wstrb = 4'b0011 << offset;
        load_ext   = {{16{~is_unsigned & shifted[15]}}, shifted[15:0]};
        bad        = offset[0];
      end
      SZ_W: begin
        lane_wdata = store_data;
        lane_wstrb = 4'b1111;
        load_ext   = load_data;
        bad        = |offset;
      end
      default: bad = 1'b1;
    endcase
  end

endmodule

// File: rtl/lsu_axi_master.sv
// AXI-lite initiator turning single LSU load/store requests into one AR/R or
// AW/W/B transaction and returning exactly one registered response pulse.
module lsu_axi_master
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] araddr,
  output logic              arvalid,
  input  logic              arready,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rvalid,
  output logic              rready,
  output logic [ADDR_W-1:0] awaddr,
  output logic              awvalid,
  input  logic              awready,
  output logic [DATA_W-1:0] wdata,
  output logic [3:0]        wstrb,
  output logic              wvalid,
  input  logic              wready,
  input  logic [1:0]        bresp,
  input  logic              bvalid,
  output logic              bready
);

  state_e            state, state_n;
  logic [1:0]        off_q, off_n;
  size_e             size_q, size_n;
  logic              uns_q, uns_n;
  logic              aw_done, aw_done_n, w_done, w_done_n;
  logic              req_ready_n, rsp_valid_n, rsp_err_n;
  logic [DATA_W-1:0] rsp_rdata_n, wdata_n;
  logic [ADDR_W-1:0] araddr_n, awaddr_n;
  logic [3:0]        wstrb_n;
  logic              arvalid_n, rready_n, awvalid_n, wvalid_n, bready_n;

  // In IDLE the aligner looks at the incoming request; afterwards at the latched one.
  logic              idle;
  logic [DATA_W-1:0] lane_wdata, load_ext;
  logic [3:0]        lane_wstrb;
  logic              bad;

  assign idle = (state == S_IDLE);

  lsu_align u_align (
    .offset      (idle ? req_addr[1:0] : off_q),
    .size        (idle ? size_e'(req_size) : size_q),
    .is_unsigned (idle ? req_unsigned : uns_q),
    .store_data  (req_wdata),
    .load_data   (rdata),
    .lane_wdata  (lane_wdata),
    .lane_wstrb  (lane_wstrb),
    .load_ext    (load_ext),
    .bad         (bad)
  );

  always_comb begin
    state_n     = state;
    off_n       = off_q;
    size_n      = size_q;
    uns_n       = uns_q;
    aw_done_n   = aw_done;
    w_done_n    = w_done;
    araddr_n    = araddr;
    arvalid_n   = arvalid;
    awaddr_n    = awaddr;
    awvalid_n   = awvalid;
    wdata_n     = wdata;
    wstrb_n     = wstrb;
    wvalid_n    = wvalid;
    rready_n    = 1'b0;
    bready_n    = 1'b0;
    rsp_valid_n = 1'b0;
    rsp_err_n   = 1'b0;
    rsp_rdata_n = '0;
    unique case (state)
      S_IDLE: if (req_valid) begin
        off_n  = req_addr[1:0];
        size_n = size_e'(req_size);
        uns_n  = req_unsigned;
        if (bad) begin
          rsp_valid_n = 1'b1;
          rsp_err_n   = 1'b1;
        end else if (req_we) begin
          state_n   = S_WR;
          awaddr_n  = {req_addr[ADDR_W-1:2], 2'b00};
          awvalid_n = 1'b1;
          wdata_n   = lane_wdata;
          wstrb_n   = lane_wstrb;
          wvalid_n  = 1'b1;
        end else begin
          state_n   = S_AR;
          araddr_n  = {req_addr[ADDR_W-1:2], 2'b00};
          arvalid_n = 1'b1;
        end
      end
      S_AR: if (arready) begin
        state_n   = S_R;
        arvalid_n = 1'b0;
        rready_n  = 1'b1;
      end
      S_R: begin
        rready_n = 1'b1;
        if (rvalid) begin
          state_n     = S_IDLE;
          rready_n    = 1'b0;
          rsp_valid_n = 1'b1;
          rsp_err_n   = (rresp != RESP_OKAY);
          rsp_rdata_n = (rresp != RESP_OKAY) ? '0 : load_ext;
        end
      end
      S_WR: begin
        // AW and W complete independently; B is entered once both have.
        if (awvalid && awready) begin
          aw_done_n = 1'b1;
          awvalid_n = 1'b0;
        end
        if (wvalid && wready) begin
          w_done_n = 1'b1;
          wvalid_n = 1'b0;
        end
        if (aw_done_n && w_done_n) begin
          state_n   = S_B;
          aw_done_n = 1'b0;
          w_done_n  = 1'b0;
          bready_n  = 1'b1;
        end
      end
      S_B: begin
        bready_n = 1'b1;
        if (bvalid) begin
          state_n     = S_IDLE;
          bready_n    = 1'b0;
          rsp_valid_n = 1'b1;
          rsp_err_n   = (bresp != RESP_OKAY);
        end
      end
      default: state_n = S_IDLE;
    endcase
    req_ready_n = (state_n == S_IDLE);
  end

  // NOTE: state is updated only with non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      off_q     <= '0;
      size_q    <= SZ_B;
      uns_q     <= 1'b0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      araddr    <= '0;
      arvalid   <= 1'b0;
      rready    <= 1'b0;
      awaddr    <= '0;
      awvalid   <= 1'b0;
      wdata     <= '0;
      wstrb     <= '0;
      wvalid    <= 1'b0;
      bready    <= 1'b0;
    end else begin
      state     <= state_n;
      off_q     <= off_n;
      size_q    <= size_n;
      uns_q     <= uns_n;
      aw_done   <= aw_done_n;
      w_done    <= w_done_n;
      req_ready <= req_ready_n;
      rsp_valid <= rsp_valid_n;
      rsp_err   <= rsp_err_n;
      rsp_rdata <= rsp_rdata_n;
      araddr    <= araddr_n;
      arvalid   <= arvalid_n;
      rready    <= rready_n;
      awaddr    <= awaddr_n;
      awvalid   <= awvalid_n;
      wdata     <= wdata_n;
      wstrb     <= wstrb_n;
      wvalid    <= wvalid_n;
      bready    <= bready_n;
    end
  end

endmodule

// File: tb/tb_lsu_axi_master.sv
// Directed bench for lsu_axi_master: the bench plays core and AXI-lite slave,
// driving on the falling edge and sampling DUT outputs on the falling edge.
module tb_lsu_axi_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 0, req_we = 0, req_unsigned = 0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [1:0]  req_size = '0;
  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] araddr, awaddr, wdata;
  logic        arvalid, rready, awvalid, wvalid, bready;
  logic [3:0]  wstrb;
  logic        arready = 0, rvalid = 0, awready = 0, wready = 0, bvalid = 0;
  logic [31:0] rdata = '0;
  logic [1:0]  rresp = '0, bresp = '0;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  lsu_axi_master dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .req_unsigned(req_unsigned),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  // Issues one load and answers as a slave; returns at the falling edge where
  // rsp_valid was seen (or the bound expired).
  task automatic run_load(input logic [31:0] addr, input logic [1:0] size, input logic uns,
                          input logic [31:0] data, input logic [1:0] resp, input int ar_stall,
                          input bit start_now, output logic [31:0] got_rdata, output logic got_err,
                          output int latency, output bit ar_ok, output bit r_ok, output bit seen);
    if (!start_now) @(negedge clk);
    req_valid = 1; req_we = 0; req_addr = addr; req_size = size; req_unsigned = uns;
    @(posedge clk);
    @(negedge clk);
    req_valid = 0; latency = 1; ar_ok = 1;
    for (int i = 0; i < ar_stall; i++) begin
      if (arvalid !== 1'b1 || araddr !== {addr[31:2], 2'b00}) ar_ok = 0;
      @(negedge clk); latency++;
    end
    if (arvalid !== 1'b1 || araddr !== {addr[31:2], 2'b00}) ar_ok = 0;
    arready = 1;
    @(negedge clk); latency++;
    arready = 0;
    r_ok = (rready === 1'b1 && arvalid === 1'b0);
    rdata = data; rresp = resp; rvalid = 1;
    @(negedge clk); latency++;
    rvalid = 0; rdata = '0; rresp = '0;
    while (rsp_valid !== 1'b1 && latency < 12) begin
      @(negedge clk); latency++;
    end
    seen = (rsp_valid === 1'b1);
    got_rdata = rsp_rdata; got_err = rsp_err;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
    vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL reset_req_ready got %b exp 1", req_ready); end
    vectors++; if ({arvalid, rready, awvalid, wvalid, bready, rsp_valid, rsp_err} !== 7'b0) begin
      miscompares++; $display("FAIL reset_ctrl got %b exp 0000000", {arvalid, rready, awvalid, wvalid, bready, rsp_valid, rsp_err}); end
    vectors++; if ({araddr, awaddr, wdata, rsp_rdata, wstrb} !== '0) begin
      miscompares++; $display("FAIL reset_data araddr %h awaddr %h wdata %h rsp_rdata %h wstrb %b exp all 0", araddr, awaddr, wdata, rsp_rdata, wstrb); end
  endtask

  task automatic test_load_word();
    logic [31:0] d; logic e; int lat; bit ao, ro, sn;
    run_load(32'h8000_0004, 2'b10, 0, 32'h1234_5678, 2'b00, 0, 0, d, e, lat, ao, ro, sn);
    vectors++; if (!sn || lat != 3) begin miscompares++; $display("FAIL ldw_latency got %0d (seen %0b) exp 3", lat, sn); end
    vectors++; if (d !== 32'h1234_5678) begin miscompares++; $display("FAIL ldw_rdata got %h exp 12345678", d); end
    vectors++; if (e !== 1'b0) begin miscompares++; $display("FAIL ldw_err got %b exp 0", e); end
    vectors++; if (!ao || !ro) begin miscompares++; $display("FAIL ldw_bus ar_ok %0b r_ok %0b exp 1 1", ao, ro); end
    vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL ldw_ready_with_rsp got %b exp 1", req_ready); end
    @(negedge clk);
    vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL ldw_pulse got %b exp 0", rsp_valid); end
  endtask

  task automatic test_load_byte();
    logic [31:0] d; logic e; int lat; bit ao, ro, sn;
    run_load(32'h8000_0003, 2'b00, 0, 32'h80FF_0000, 2'b00, 0, 0, d, e, lat, ao, ro, sn);
    vectors++; if (!sn || d !== 32'hFFFF_FF80 || e !== 1'b0) begin
      miscompares++; $display("FAIL ldb_signed got %h err %b exp ffffff80 err 0", d, e); end
    run_load(32'h8000_0003, 2'b00, 1, 32'h80FF_0000, 2'b00, 0, 0, d, e, lat, ao, ro, sn);
    vectors++; if (!sn || d !== 32'h0000_0080 || e !== 1'b0) begin
      miscompares++; $display("FAIL ldb_unsigned got %h err %b exp 00000080 err 0", d, e); end
    run_load(32'h8000_0001, 2'b00, 0, 32'h0000_7F00, 2'b00, 0, 0, d, e, lat, ao, ro, sn);
    vectors++; if (!sn || d !== 32'h0000_007F) begin miscompares++; $display("FAIL ldb_lane1 got %h exp 0000007f", d); end
  endtask

  task automatic test_load_stall_err();
    logic [31:0] d; logic e; int lat; bit ao, ro, sn;
    run_load(32'h8000_0010, 2'b10, 0, 32'hDEAD_BEEF, 2'b10, 5, 0, d, e, lat, ao, ro, sn);
    vectors++; if (!ao) begin miscompares++; $display("FAIL stall_ar_stable got 0 exp 1"); end
    vectors++; if (!sn || lat != 8) begin miscompares++; $display("FAIL stall_latency got %0d (seen %0b) exp 8", lat, sn); end
    vectors++; if (e !== 1'b1 || d !== 32'h0) begin miscompares++; $display("FAIL stall_slverr got err %b rdata %h exp 1 00000000", e, d); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d; logic e; int lat; bit ao, ro, sn;
    run_load(32'h8000_0008, 2'b10, 0, 32'h0BAD_F00D, 2'b00, 0, 0, d, e, lat, ao, ro, sn);
    vectors++; if (!sn || d !== 32'h0BAD_F00D) begin miscompares++; $display("FAIL b2b_first got %h exp 0badf00d", d); end
    run_load(32'h8000_0002, 2'b01, 0, 32'h8001_1234, 2'b00, 0, 1, d, e, lat, ao, ro, sn);
    vectors++; if (!sn || lat != 3 || !ao) begin miscompares++; $display("FAIL b2b_second_timing got lat %0d ar_ok %0b exp 3 1", lat, ao); end
    vectors++; if (d !== 32'hFFFF_8001 || e !== 1'b0) begin miscompares++; $display("FAIL b2b_half_signed got %h err %b exp ffff8001 0", d, e); end
  endtask

  task automatic test_store_half();
    @(negedge clk);
    req_valid = 1; req_we = 1; req_addr = 32'h8000_0002; req_size = 2'b01; req_wdata = 32'h0000_BEEF;
    @(posedge clk);
    @(negedge clk);
    req_valid = 0; req_we = 0;
    vectors++; if (awvalid !== 1'b1 || wvalid !== 1'b1 || awaddr !== 32'h8000_0000) begin
      miscompares++; $display("FAIL sth_issue awvalid %b wvalid %b awaddr %h exp 1 1 80000000", awvalid, wvalid, awaddr); end
    vectors++; if (wdata !== 32'hBEEF_BEEF || wstrb !== 4'b1100) begin
      miscompares++; $display("FAIL sth_lanes wdata %h wstrb %b exp beefbeef 1100", wdata, wstrb); end
    awready = 1;
    @(negedge clk);
    awready = 0;
    vectors++; if (awvalid !== 1'b0 || wvalid !== 1'b1 || bready !== 1'b0) begin
      miscompares++; $display("FAIL sth_aw_drop awvalid %b wvalid %b bready %b exp 0 1 0", awvalid, wvalid, bready); end
    @(negedge clk);
    vectors++; if (wvalid !== 1'b1 || wdata !== 32'hBEEF_BEEF || wstrb !== 4'b1100) begin
      miscompares++; $display("FAIL sth_w_stable wvalid %b wdata %h wstrb %b exp 1 beefbeef 1100", wvalid, wdata, wstrb); end
    wready = 1;
    @(negedge clk);
    wready = 0;
    vectors++; if (wvalid !== 1'b0 || bready !== 1'b1) begin
      miscompares++; $display("FAIL sth_enter_b wvalid %b bready %b exp 0 1", wvalid, bready); end
    bvalid = 1; bresp = 2'b00;
    @(negedge clk);
    bvalid = 0;
    vectors++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0 || bready !== 1'b0) begin
      miscompares++; $display("FAIL sth_rsp valid %b err %b rdata %h bready %b exp 1 0 0 0", rsp_valid, rsp_err, rsp_rdata, bready); end
  endtask

  task automatic test_store_byte_simul();
    @(negedge clk);
    req_valid = 1; req_we = 1; req_addr = 32'h8000_0001; req_size = 2'b00; req_wdata = 32'h1234_56A5;
    @(posedge clk);
    @(negedge clk);
    req_valid = 0; req_we = 0;
    vectors++; if (wdata !== 32'hA5A5_A5A5 || wstrb !== 4'b0010 || awaddr !== 32'h8000_0000) begin
      miscompares++; $display("FAIL stb_lanes wdata %h wstrb %b awaddr %h exp a5a5a5a5 0010 80000000", wdata, wstrb, awaddr); end
    awready = 1; wready = 1;
    @(negedge clk);
    awready = 0; wready = 0;
    vectors++; if (awvalid !== 1'b0 || wvalid !== 1'b0 || bready !== 1'b1) begin
      miscompares++; $display("FAIL stb_direct_b awvalid %b wvalid %b bready %b exp 0 0 1", awvalid, wvalid, bready); end
    bvalid = 1; bresp = 2'b10;
    @(negedge clk);
    bvalid = 0; bresp = 2'b00;
    vectors++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0) begin
      miscompares++; $display("FAIL stb_bresp_err valid %b err %b rdata %h exp 1 1 0", rsp_valid, rsp_err, rsp_rdata); end
  endtask

  task automatic test_misaligned();
    logic [31:0] addrs [4] = '{32'h8000_0001, 32'h8000_0003, 32'h8000_0000, 32'h8000_0001};
    logic [1:0]  sizes [4] = '{2'b10, 2'b01, 2'b11, 2'b01};
    logic        wes   [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      req_valid = 1; req_we = wes[i]; req_addr = addrs[i]; req_size = sizes[i]; req_wdata = 32'hFFFF_FFFF;
      @(posedge clk);
      @(negedge clk);
      req_valid = 0; req_we = 0;
      vectors++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0 || req_ready !== 1'b1) begin
        miscompares++; $display("FAIL misalign_rsp[%0d] valid %b err %b rdata %h ready %b exp 1 1 0 1", i, rsp_valid, rsp_err, rsp_rdata, req_ready); end
      @(negedge clk);
      vectors++; if ({arvalid, awvalid, wvalid, rsp_valid} !== 4'b0) begin
        miscompares++; $display("FAIL misalign_quiet[%0d] ar %b aw %b w %b rsp %b exp 0 0 0 0", i, arvalid, awvalid, wvalid, rsp_valid); end
    end
  endtask

  task automatic test_rst_mid();
    logic [31:0] d; logic e; int lat; bit ao, ro, sn;
    @(negedge clk);
    req_valid = 1; req_we = 0; req_addr = 32'h8000_0020; req_size = 2'b10;
    @(posedge clk);
    @(negedge clk);
    req_valid = 0; arready = 1;
    @(negedge clk);
    arready = 0;
    vectors++; if (rready !== 1'b1) begin miscompares++; $display("FAIL rst_mid_in_r rready %b exp 1", rready); end
    rst = 1;
    @(negedge clk);
    rst = 0;
    vectors++; if (rready !== 1'b0 || arvalid !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      miscompares++; $display("FAIL rst_mid_idle rready %b arvalid %b rsp %b ready %b exp 0 0 0 1", rready, arvalid, rsp_valid, req_ready); end
    rvalid = 1; rdata = 32'h5555_AAAA;
    @(negedge clk);
    rvalid = 0; rdata = '0;
    vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL rst_mid_dropped rsp_valid %b exp 0", rsp_valid); end
    run_load(32'h8000_0024, 2'b10, 0, 32'hCAFE_0001, 2'b00, 0, 0, d, e, lat, ao, ro, sn);
    vectors++; if (!sn || lat != 3 || d !== 32'hCAFE_0001 || e !== 1'b0) begin
      miscompares++; $display("FAIL rst_mid_recover lat %0d rdata %h err %b exp 3 cafe0001 0", lat, d, e); end
  endtask

  initial begin
    test_reset();
    test_load_word();
    test_load_byte();
    test_store_half();
    test_store_byte_simul();
    test_misaligned();
    test_load_stall_err();
    test_back_to_back();
    test_rst_mid();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
